// File: rtl/mips_wb_arbiter.sv
// rtl/mips_wb_arbiter.sv - register-file write-port arbiter between pipeline WB and a 2-entry multi-cycle result FIFO
`ifndef MIPS_RFIDX_WIDTH
`define MIPS_RFIDX_WIDTH 5
`endif
`ifndef MIPS_DATA_WIDTH
`define MIPS_DATA_WIDTH 32
`endif

module mips_wb_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         pipe_wb_en,
  input  logic [`MIPS_RFIDX_WIDTH-1:0] pipe_wb_idx,
  input  logic [`MIPS_DATA_WIDTH-1:0]  pipe_wb_dat,
  input  logic                         md_valid,
  output logic                         md_ready,
  input  logic [`MIPS_RFIDX_WIDTH-1:0] md_idx,
  input  logic [`MIPS_DATA_WIDTH-1:0]  md_dat,
  output logic                         pipe_stall,
  output logic                         wb_dest_en,
  output logic [`MIPS_RFIDX_WIDTH-1:0] wb_dest_idx,
  output logic [`MIPS_DATA_WIDTH-1:0]  wb_dest_dat,
  input  logic [`MIPS_RFIDX_WIDTH-1:0] chk_rs_idx,
  input  logic [`MIPS_RFIDX_WIDTH-1:0] chk_rt_idx,
  output logic                         chk_rs_pend,
  output logic                         chk_rt_pend,
  output logic [1:0]                   fifo_cnt
);

  localparam int IW = `MIPS_RFIDX_WIDTH;
  localparam int DW = `MIPS_DATA_WIDTH;
  localparam logic [3:0] STARVE_LIM  = 4'(STARVE_MAX);
  localparam logic [3:0] STARVE_TRIG = 4'(STARVE_MAX - 1);

  logic [IW-1:0] ent_idx [2];
  logic [DW-1:0] ent_dat [2];
  logic          rd_ptr;
  logic          wr_ptr;
  logic [1:0]    cnt_q;
  logic [3:0]    starve_q;
  logic          stall_q;
  logic [1:0]    ent_vld;
  logic          fifo_ne;
  logic          pipe_req;
  logic          push;
  logic          pop;

  // Index 0 is the hardwired zero register: such writes are never requests
  assign fifo_ne  = (cnt_q != 2'd0);
  assign md_ready = (cnt_q != 2'd2) & ~rst;
  assign push     = md_valid & md_ready & (md_idx != '0);
  assign pipe_req = pipe_wb_en & (pipe_wb_idx != '0);

  assign pipe_stall = stall_q;
  assign fifo_cnt   = cnt_q;

  // Port grant: a forced stall gives the FIFO head priority, otherwise the pipeline wins
  always_comb begin
    pop         = 1'b0;
    wb_dest_en  = 1'b0;
    wb_dest_idx = '0;
    wb_dest_dat = '0;
    if (!rst) begin
      if (stall_q && fifo_ne) begin
        pop         = 1'b1;
        wb_dest_en  = 1'b1;
        wb_dest_idx = ent_idx[rd_ptr];
        wb_dest_dat = ent_dat[rd_ptr];
      end else if (pipe_req) begin
        wb_dest_en  = 1'b1;
        wb_dest_idx = pipe_wb_idx;
        wb_dest_dat = pipe_wb_dat;
      end else if (fifo_ne) begin
        pop         = 1'b1;
        wb_dest_en  = 1'b1;
        wb_dest_idx = ent_idx[rd_ptr];
        wb_dest_dat = ent_dat[rd_ptr];
      end
    end
  end

  // Which of the two slots currently hold a queued result
  always_comb begin
    ent_vld          = '0;
    ent_vld[rd_ptr]  = fifo_ne;
    ent_vld[~rd_ptr] = (cnt_q == 2'd2);
  end

  assign chk_rs_pend = (chk_rs_idx != '0) &
                       ((ent_vld[0] & (ent_idx[0] == chk_rs_idx)) |
                        (ent_vld[1] & (ent_idx[1] == chk_rs_idx)));
  assign chk_rt_pend = (chk_rt_idx != '0) &
                       ((ent_vld[0] & (ent_idx[0] == chk_rt_idx)) |
                        (ent_vld[1] & (ent_idx[1] == chk_rt_idx)));

  // Slot payload storage; validity is tracked by the pointers and count
  always_ff @(posedge clk) begin
    if (push) begin
      ent_idx[wr_ptr] <= md_idx;
      ent_dat[wr_ptr] <= md_dat;
    end
  end

  // Circular-buffer pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Starvation counter: counts consecutive cycles the head waited for the port
  always_ff @(posedge clk) begin
    if (rst || pop || !fifo_ne) begin
      starve_q <= 4'd0;
    end else if (starve_q != STARVE_LIM) begin
      starve_q <= starve_q + 4'd1;
    end
  end

  // One-cycle stall request once the head has waited STARVE_MAX cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= 1'b0;
    end else begin
      stall_q <= fifo_ne & ~pop & (starve_q == STARVE_TRIG);
    end
  end

endmodule

// File: tb/tb_mips_wb_arbiter.sv
// tb/tb_mips_wb_arbiter.sv - randomized and directed bench for mips_wb_arbiter against a queue-based model
`ifndef MIPS_RFIDX_WIDTH
`define MIPS_RFIDX_WIDTH 5
`endif
`ifndef MIPS_DATA_WIDTH
`define MIPS_DATA_WIDTH 32
`endif

module tb_mips_wb_arbiter;

  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_wb_en;
  logic [4:0]  pipe_wb_idx;
  logic [31:0] pipe_wb_dat;
  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_idx;
  logic [31:0] md_dat;
  logic        pipe_stall;
  logic        wb_dest_en;
  logic [4:0]  wb_dest_idx;
  logic [31:0] wb_dest_dat;
  logic [4:0]  chk_rs_idx;
  logic [4:0]  chk_rt_idx;
  logic        chk_rs_pend;
  logic        chk_rt_pend;
  logic [1:0]  fifo_cnt;

  mips_wb_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .pipe_wb_en(pipe_wb_en), .pipe_wb_idx(pipe_wb_idx), .pipe_wb_dat(pipe_wb_dat),
    .md_valid(md_valid), .md_ready(md_ready), .md_idx(md_idx), .md_dat(md_dat),
    .pipe_stall(pipe_stall),
    .wb_dest_en(wb_dest_en), .wb_dest_idx(wb_dest_idx), .wb_dest_dat(wb_dest_dat),
    .chk_rs_idx(chk_rs_idx), .chk_rt_idx(chk_rt_idx),
    .chk_rs_pend(chk_rs_pend), .chk_rt_pend(chk_rt_pend),
    .fifo_cnt(fifo_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: queued results in arrival order, waited-cycle count, and the stall it implies
  typedef struct {
    logic [4:0]  idx;
    logic [31:0] dat;
  } ent_t;

  ent_t        q[$];
  int          starved = 0;
  bit          stall_m = 1'b0;

  bit          m_ready, m_en, m_pop, m_push, m_rs, m_rt, m_nxt;
  logic [4:0]  m_idx;
  logic [31:0] m_dat;

  // Compare DUT against the model mid-cycle, then advance the model to the next edge
  always @(negedge clk) begin
    m_ready = !rst && (q.size() < 2);
    m_en = 1'b0; m_idx = '0; m_dat = '0; m_pop = 1'b0;
    if (!rst) begin
      if (stall_m && q.size() > 0) begin
        m_en = 1'b1; m_idx = q[0].idx; m_dat = q[0].dat; m_pop = 1'b1;
      end else if (pipe_wb_en && pipe_wb_idx != 0) begin
        m_en = 1'b1; m_idx = pipe_wb_idx; m_dat = pipe_wb_dat;
      end else if (q.size() > 0) begin
        m_en = 1'b1; m_idx = q[0].idx; m_dat = q[0].dat; m_pop = 1'b1;
      end
    end
    m_rs = 1'b0; m_rt = 1'b0;
    foreach (q[k]) begin
      if (chk_rs_idx != 0 && q[k].idx == chk_rs_idx) m_rs = 1'b1;
      if (chk_rt_idx != 0 && q[k].idx == chk_rt_idx) m_rt = 1'b1;
    end
    if (cmp_en) begin
      chk("md_ready", {31'd0, md_ready}, {31'd0, m_ready});
      chk("wb_dest_en", {31'd0, wb_dest_en}, {31'd0, m_en});
      if (!rst) begin
        chk("wb_dest_idx", {27'd0, wb_dest_idx}, {27'd0, m_idx});
        chk("wb_dest_dat", wb_dest_dat, m_dat);
      end
      chk("pipe_stall", {31'd0, pipe_stall}, {31'd0, stall_m});
      chk("fifo_cnt", {30'd0, fifo_cnt}, q.size());
      chk("chk_rs_pend", {31'd0, chk_rs_pend}, {31'd0, m_rs});
      chk("chk_rt_pend", {31'd0, chk_rt_pend}, {31'd0, m_rt});
    end
    if (rst) begin
      q.delete();
      starved = 0;
      stall_m = 1'b0;
    end else begin
      m_nxt  = (q.size() > 0) && !m_pop && (starved + 1 == STARVE_MAX);
      m_push = md_valid && m_ready && (md_idx != 0);
      if (m_pop || q.size() == 0) starved = 0;
      else if (starved < STARVE_MAX) starved++;
      if (m_pop) void'(q.pop_front());
      if (m_push) q.push_back('{idx: md_idx, dat: md_dat});
      stall_m = m_nxt;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pipe(input bit en, input logic [4:0] idx, input logic [31:0] dat);
    pipe_wb_en = en; pipe_wb_idx = idx; pipe_wb_dat = dat;
  endtask

  task automatic md(input bit v, input logic [4:0] idx, input logic [31:0] dat);
    md_valid = v; md_idx = idx; md_dat = dat;
  endtask

  initial begin
    rst = 1'b1;
    pipe(0, 0, 0);
    md(0, 0, 0);
    chk_rs_idx = 0; chk_rt_idx = 0;
    @(posedge clk); #1;
    cmp_en = 1'b1;
    cyc();
    #2;
    chk("rst fifo_cnt", {30'd0, fifo_cnt}, 0);
    chk("rst md_ready", {31'd0, md_ready}, 0);
    chk("rst wb_dest_en", {31'd0, wb_dest_en}, 0);
    chk("rst pipe_stall", {31'd0, pipe_stall}, 0);

    // Pipeline write straight through an idle FIFO
    cyc(); rst = 1'b0; pipe(1, 5, 32'hDEADBEEF);
    #2;
    chk("t1 en", {31'd0, wb_dest_en}, 1);
    chk("t1 idx", {27'd0, wb_dest_idx}, 5);
    chk("t1 dat", wb_dest_dat, 32'hDEADBEEF);
    chk("t1 cnt", {30'd0, fifo_cnt}, 0);

    // Single md result queued then drained on the free port
    cyc(); pipe(0, 0, 0); md(1, 3, 32'h11); chk_rs_idx = 3;
    #2;
    chk("t2 pend before push", {31'd0, chk_rs_pend}, 0);
    cyc(); md(0, 0, 0);
    #2;
    chk("t2 cnt", {30'd0, fifo_cnt}, 1);
    chk("t2 pend", {31'd0, chk_rs_pend}, 1);
    chk("t2 idx", {27'd0, wb_dest_idx}, 3);
    chk("t2 dat", wb_dest_dat, 32'h11);
    cyc();
    #2;
    chk("t2 cnt after", {30'd0, fifo_cnt}, 0);
    chk("t2 pend after", {31'd0, chk_rs_pend}, 0);

    // Starvation: pipeline hogs the port, FIFO fills, stalls drain in order
    cyc(); pipe(1, 4, 32'h44); md(1, 7, 32'h70);
    cyc(); md(1, 8, 32'h80);
    cyc(); md(0, 0, 0); chk_rs_idx = 7; chk_rt_idx = 8;
    #2;
    chk("t3 cnt", {30'd0, fifo_cnt}, 2);
    chk("t3 md_ready", {31'd0, md_ready}, 0);
    chk("t3 rs pend", {31'd0, chk_rs_pend}, 1);
    chk("t3 rt pend", {31'd0, chk_rt_pend}, 1);
    cyc();
    cyc();
    #2;
    chk("t3 no stall yet", {31'd0, pipe_stall}, 0);
    chk("t3 pipe idx", {27'd0, wb_dest_idx}, 4);
    cyc(); pipe(0, 0, 0);
    #2;
    chk("t3 stall1", {31'd0, pipe_stall}, 1);
    chk("t3 drain1 idx", {27'd0, wb_dest_idx}, 7);
    chk("t3 drain1 dat", wb_dest_dat, 32'h70);
    cyc(); pipe(1, 4, 32'h44);
    #2;
    chk("t3 stall one cycle", {31'd0, pipe_stall}, 0);
    chk("t3 cnt1", {30'd0, fifo_cnt}, 1);
    cyc(); cyc(); cyc();
    cyc(); pipe(0, 0, 0);
    #2;
    chk("t3 stall2", {31'd0, pipe_stall}, 1);
    chk("t3 drain2 idx", {27'd0, wb_dest_idx}, 8);
    chk("t3 drain2 dat", wb_dest_dat, 32'h80);
    cyc();
    #2;
    chk("t3 cnt0", {30'd0, fifo_cnt}, 0);
    chk("t3 stall cleared", {31'd0, pipe_stall}, 0);

    // Simultaneous push and pop keeps count and order
    chk_rs_idx = 0; chk_rt_idx = 0;
    cyc(); pipe(1, 4, 32'h44); md(1, 9, 32'h90);
    cyc(); pipe(0, 0, 0); md(1, 10, 32'hA0);
    #2;
    chk("t4 pop old idx", {27'd0, wb_dest_idx}, 9);
    chk("t4 cnt", {30'd0, fifo_cnt}, 1);
    cyc(); md(0, 0, 0);
    #2;
    chk("t4 cnt held", {30'd0, fifo_cnt}, 1);
    chk("t4 new idx", {27'd0, wb_dest_idx}, 10);
    chk("t4 new dat", wb_dest_dat, 32'hA0);

    // Index-0 requests from both sides are ignored; queued entry drains
    cyc(); pipe(1, 4, 32'h44); md(1, 12, 32'hC0);
    cyc(); pipe(1, 0, 32'h77); md(1, 0, 32'h55);
    #2;
    chk("t5 drain idx", {27'd0, wb_dest_idx}, 12);
    chk("t5 drain dat", wb_dest_dat, 32'hC0);
    cyc(); pipe(0, 0, 0); md(0, 0, 0);
    #2;
    chk("t5 no entry", {30'd0, fifo_cnt}, 0);
    chk("t5 no write", {31'd0, wb_dest_en}, 0);

    // Reset with a full FIFO and the counter one short of a stall
    cyc(); pipe(1, 4, 32'h44); md(1, 13, 32'hD0);
    cyc(); md(1, 14, 32'hE0);
    cyc(); md(0, 0, 0);
    cyc();
    cyc(); rst = 1'b1;
    #2;
    chk("t6 rst en", {31'd0, wb_dest_en}, 0);
    chk("t6 rst ready", {31'd0, md_ready}, 0);
    cyc(); rst = 1'b0; pipe(0, 0, 0);
    #2;
    chk("t6 cnt", {30'd0, fifo_cnt}, 0);
    chk("t6 stall", {31'd0, pipe_stall}, 0);
    chk("t6 ready", {31'd0, md_ready}, 1);
    chk("t6 no write", {31'd0, wb_dest_en}, 0);

    // Randomized traffic checked every cycle by the model
    for (int i = 0; i < 3000; i++) begin
      cyc();
      rst = ($urandom_range(0, 99) == 0);
      md_valid = $urandom_range(0, 1) == 1;
      md_idx = 5'($urandom_range(0, 7));
      md_dat = $urandom;
      pipe_wb_en = $urandom_range(0, 9) < 6;
      pipe_wb_idx = 5'($urandom_range(0, 7));
      pipe_wb_dat = $urandom;
      if (stall_m && $urandom_range(0, 19) != 0) pipe_wb_en = 1'b0;
      chk_rs_idx = 5'($urandom_range(0, 7));
      chk_rt_idx = 5'($urandom_range(0, 7));
    end
    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
